jtsdram_stats: RTL



---
 rtl/jtsdram_pkg.sv | 16 +
 rtl/jtsdram_stats_bank.sv | 76 +++++++
 rtl/jtsdram_stats.sv | 117 +++++++++++
 3 files changed

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM checker statistics: tracker state encoding
// and default sizing constants.
package jtsdram_pkg;

    localparam int NBANK    = 4;
    localparam int DEF_LATW = 8;
    localparam int DEF_CNTW = 16;
    localparam int DEF_TOUT = 200;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RDY = 2'd2
    } bank_state_t;

endpackage

// File: rtl/jtsdram_stats_bank.sv
// One bank read tracker: measures rd->rdy latency, keeps the worst case,
// counts completed reads and flags requests that never see rdy.
module jtsdram_stats_bank
    import jtsdram_pkg::*;
#(
    parameter int LATW = DEF_LATW,
    parameter int CNTW = DEF_CNTW,
    parameter int TOUT = DEF_TOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            rd,
    input  logic            ack,
    input  logic            rdy,
    output logic [LATW-1:0] max_lat,
    output logic [CNTW-1:0] rd_cnt,
    output logic            tout
);

    bank_state_t     state, state_nx;
    logic [LATW-1:0] lat, lat_inc;
    logic            start, busy, done, expire;

    // lat holds k-1 at the edge where rdy is seen, so lat_inc is the measured k
    assign lat_inc = (&lat) ? lat : lat + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clr)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (start) state_nx = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (done || expire) state_nx = ST_IDLE;
                else if (ack)       state_nx = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: if (done || expire) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // rdy wins over the timeout when both land on the same edge
    always_comb begin
        busy   = (state == ST_WAIT_ACK) || (state == ST_WAIT_RDY);
        start  = (state == ST_IDLE) && rd;
        done   = busy && rdy;
        expire = busy && !rdy && (lat_inc >= LATW'(TOUT));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lat     <= '0;
            max_lat <= '0;
            rd_cnt  <= '0;
            tout    <= 1'b0;
        end else begin
            if (start)
                lat <= '0;
            else if (busy)
                lat <= lat_inc;
            if (done) begin
                if (lat_inc > max_lat) max_lat <= lat_inc;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (expire)
                tout <= 1'b1;
        end
    end

endmodule

// File: rtl/jtsdram_stats.sv
// SDRAM checker statistics: per-bank trackers, pass/bad bookkeeping and a
// snapshot frozen at the start of vertical blank for the on-screen display.
module jtsdram_stats
    import jtsdram_pkg::*;
#(
    parameter int LATW = DEF_LATW,
    parameter int CNTW = DEF_CNTW,
    parameter int TOUT = DEF_TOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LVBL,
    input  logic             clr,
    input  logic             dwnld_busy,
    input  logic             bad,
    input  logic [NBANK-1:0] ba_rd,
    input  logic [NBANK-1:0] ba_ack,
    input  logic [NBANK-1:0] ba_rdy,
    input  logic [1:0]       sel,
    output logic [CNTW-1:0]  st_pass,
    output logic             st_bad,
    output logic [CNTW-1:0]  st_bad_pass,
    output logic [NBANK-1:0] st_tout,
    output logic [LATW-1:0]  st_max_lat,
    output logic [CNTW-1:0]  st_rd_cnt
);

    logic [NBANK-1:0][LATW-1:0] max_lat, snap_max_lat;
    logic [NBANK-1:0][CNTW-1:0] rd_cnt, snap_rd_cnt;
    logic [NBANK-1:0]           tout;

    logic            lvbl_r, lvbl_rr, busy_r, busy_rr;
    logic            snap_en, busy_fall;
    logic [CNTW-1:0] pass_cnt, bad_pass;
    logic            bad_lat;

    for (genvar n = 0; n < NBANK; n++) begin : g_bank
        jtsdram_stats_bank #(
            .LATW (LATW),
            .CNTW (CNTW),
            .TOUT (TOUT)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .rd      (ba_rd[n]),
            .ack     (ba_ack[n]),
            .rdy     (ba_rdy[n]),
            .max_lat (max_lat[n]),
            .rd_cnt  (rd_cnt[n]),
            .tout    (tout[n])
        );
    end

    // Two-stage edge detectors: a fall sampled at edge e acts at edge e+1
    always_ff @(posedge clk) begin
        if (rst) begin
            lvbl_r  <= 1'b0;
            lvbl_rr <= 1'b0;
            busy_r  <= 1'b0;
            busy_rr <= 1'b0;
        end else begin
            lvbl_r  <= LVBL;
            lvbl_rr <= lvbl_r;
            busy_r  <= dwnld_busy;
            busy_rr <= busy_r;
        end
    end

    assign snap_en   = lvbl_rr && !lvbl_r;
    assign busy_fall = busy_rr && !busy_r;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pass_cnt <= '0;
            bad_lat  <= 1'b0;
            bad_pass <= '0;
        end else begin
            if (busy_fall)
                pass_cnt <= pass_cnt + 1'b1;
            if (bad && !bad_lat) begin
                bad_lat  <= 1'b1;
                bad_pass <= pass_cnt;
            end
        end
    end

    // Snapshot ignores clr so a coinciding clear still freezes pre-clear values
    always_ff @(posedge clk) begin
        if (rst) begin
            st_pass      <= '0;
            st_bad       <= 1'b0;
            st_bad_pass  <= '0;
            st_tout      <= '0;
            snap_max_lat <= '0;
            snap_rd_cnt  <= '0;
        end else if (snap_en) begin
            st_pass      <= pass_cnt;
            st_bad       <= bad_lat;
            st_bad_pass  <= bad_pass;
            st_tout      <= tout;
            snap_max_lat <= max_lat;
            snap_rd_cnt  <= rd_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_max_lat <= '0;
            st_rd_cnt  <= '0;
        end else begin
            st_max_lat <= snap_max_lat[sel];
            st_rd_cnt  <= snap_rd_cnt[sel];
        end
    end

endmodule
